sipo_deserializer: RTL and testbench

- Serial-in/parallel-out deserializer that sits directly downstream of the D flip-flop stage and consumes its registered `out` bit stream.
- Accumulates WIDTH bits, qualified by `shift_en`, into a shift register.
- Each completed word is transferred to an output holding register and offered with a valid/ready handshake.
- A completed word that cannot be accepted is dropped, and the condition is flagged as an overrun.

---
 rtl/deser_pkg.sv | 11 +
 rtl/deser_shift_reg.sv | 59 +++++
 rtl/sipo_deserializer.sv | 96 +++++++++
 tb/tb_sipo_deserializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
package deser_pkg;

    typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_state_t;

    // Bits needed to count from 0 up to and including w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// Serial shift register with bit counter. It flags the edge that completes a word
// and presents the whole word, including that final bit, on the same cycle.
module deser_shift_reg
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                           clk,
    input  logic                           async_reset,
    input  logic                           serial_in,
    input  logic                           shift_en,
    input  logic                           flush,
    output logic [WIDTH-1:0]               word,
    output logic                           word_done,
    output logic [cnt_width(WIDTH)-1:0]    bit_count
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_shift_next;
    logic             w_shift;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_next = {r_shift[WIDTH-2:0], serial_in};
        end else begin : g_lsb_first
            assign w_shift_next = {serial_in, r_shift[WIDTH-1:1]};
        end
    endgenerate

    // Flush wins over shift_en, so a flushed bit can never complete a word.
    assign w_shift   = shift_en & ~flush;
    assign word_done = w_shift & (r_count == LAST);
    assign word      = w_shift_next;
    assign bit_count = r_count;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_shift) begin
            if (word_done) begin
                r_shift <= '0;
                r_count <= '0;
            end else begin
                r_shift <= w_shift_next;
                r_count <= r_count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Deserializer top: shift register feeding a one-deep holding register offered
// over valid/ready; words completed while the holder is blocked are dropped.
module sipo_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                           clk,
    input  logic                           async_reset,
    input  logic                           serial_in,
    input  logic                           shift_en,
    input  logic                           flush,
    output logic [WIDTH-1:0]               data_out,
    output logic                           data_valid,
    input  logic                           data_ready,
    output logic [cnt_width(WIDTH)-1:0]    bit_count,
    output logic                           overrun
);

    logic [WIDTH-1:0] w_word;
    logic             w_word_done;
    hold_state_t      r_state;
    hold_state_t      w_state_next;
    logic             w_load;
    logic             w_drop;
    logic [WIDTH-1:0] r_data;
    logic             r_overrun;

    deser_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk         (clk),
        .async_reset (async_reset),
        .serial_in   (serial_in),
        .shift_en    (shift_en),
        .flush       (flush),
        .word        (w_word),
        .word_done   (w_word_done),
        .bit_count   (bit_count)
    );

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_state <= HOLD_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            HOLD_EMPTY: begin
                if (w_word_done) begin
                    w_state_next = HOLD_FULL;
                    w_load       = 1'b1;
                end
            end
            HOLD_FULL: begin
                if (w_word_done) begin
                    // Consumer taking the old word frees the slot for the new one.
                    w_load = data_ready;
                    w_drop = ~data_ready;
                end else if (data_ready) begin
                    w_state_next = HOLD_EMPTY;
                end
            end
            default: w_state_next = HOLD_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_data <= w_word;
            end
            if (flush) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = (r_state == HOLD_FULL);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: two instances (MSB-first and LSB-first) share inputs;
// table vectors, hand sequences and random traffic are checked against a word-level model.
module tb_sipo_deserializer;

    localparam int W = 8;

    logic       clk;
    logic       async_reset;
    logic       serial_in;
    logic       shift_en;
    logic       flush;
    logic       data_ready;

    logic [W-1:0] data_a, data_b;
    logic         valid_a, valid_b;
    logic [3:0]   count_a, count_b;
    logic         ovr_a, ovr_b;

    int total = 0;
    int bad   = 0;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1)) dut_a (
        .clk(clk), .async_reset(async_reset), .serial_in(serial_in),
        .shift_en(shift_en), .flush(flush), .data_out(data_a),
        .data_valid(valid_a), .data_ready(data_ready),
        .bit_count(count_a), .overrun(ovr_a)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(0)) dut_b (
        .clk(clk), .async_reset(async_reset), .serial_in(serial_in),
        .shift_en(shift_en), .flush(flush), .data_out(data_b),
        .data_valid(valid_b), .data_ready(data_ready),
        .bit_count(count_b), .overrun(ovr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word-level reference: received bits kept in a queue, words built arithmetically.
    int     m_bits[$];
    logic   m_valid;
    int     m_data_a, m_data_b;
    logic   m_ovr;
    int     hs_q[$];

    task automatic model_reset();
        m_bits.delete();
        m_valid  = 1'b0;
        m_data_a = 0;
        m_data_b = 0;
        m_ovr    = 1'b0;
    endtask

    task automatic model_edge(input logic se, input logic si, input logic fl, input logic rdy);
        logic done;
        int   wa, wb;
        done = 1'b0;
        wa   = 0;
        wb   = 0;
        if (fl) begin
            m_bits.delete();
            m_ovr = 1'b0;
        end else if (se) begin
            m_bits.push_back(int'(si));
            if (m_bits.size() == W) begin
                done = 1'b1;
                for (int i = 0; i < W; i++) begin
                    wa = wa * 2 + m_bits[i];
                    wb = wb + (m_bits[i] << i);
                end
                m_bits.delete();
            end
        end
        if (!m_valid) begin
            if (done) begin
                m_valid  = 1'b1;
                m_data_a = wa;
                m_data_b = wb;
            end
        end else if (done) begin
            if (rdy) begin
                m_data_a = wa;
                m_data_b = wb;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".a_valid"}, 32'(valid_a), 32'(m_valid));
        chk({tag, ".a_data"},  32'(data_a),  m_data_a);
        chk({tag, ".a_count"}, 32'(count_a), m_bits.size());
        chk({tag, ".a_ovr"},   32'(ovr_a),   32'(m_ovr));
        chk({tag, ".b_valid"}, 32'(valid_b), 32'(m_valid));
        chk({tag, ".b_data"},  32'(data_b),  m_data_b);
        chk({tag, ".b_count"}, 32'(count_b), m_bits.size());
        chk({tag, ".b_ovr"},   32'(ovr_b),   32'(m_ovr));
    endtask

    // Called 1 time unit after a rising edge; drives inputs and advances one edge.
    task automatic step(input logic se, input logic si, input logic fl, input logic rdy, input string tag);
        if (valid_a && rdy) hs_q.push_back(int'(data_a));
        shift_en   = se;
        serial_in  = si;
        flush      = fl;
        data_ready = rdy;
        @(posedge clk);
        model_edge(se, si, fl, rdy);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic       se, si, fl, rdy;
        logic       ev;
        logic [7:0] ed;
        logic [7:0] edb;
        logic [3:0] ec;
        logic       eo;
    } vec_t;

    vec_t vecs[$];

    task automatic add_row(input logic se, input logic si, input logic fl, input logic rdy,
                           input logic ev, input logic [7:0] ed, input logic [7:0] edb,
                           input logic [3:0] ec, input logic eo);
        vec_t v;
        v.se = se; v.si = si; v.fl = fl; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.edb = edb; v.ec = ec; v.eo = eo;
        vecs.push_back(v);
    endtask

    // One byte sent MSB of the literal first; data_ready only on the final bit.
    task automatic add_byte(input logic [7:0] b, input logic rdy_last,
                            input logic ev_d, input logic [7:0] ed_d, input logic [7:0] edb_d, input logic eo_d,
                            input logic ev_e, input logic [7:0] ed_e, input logic [7:0] edb_e, input logic eo_e);
        for (int i = 0; i < 7; i++)
            add_row(1'b1, b[7-i], 1'b0, 1'b0, ev_d, ed_d, edb_d, 4'(i + 1), eo_d);
        add_row(1'b1, b[0], 1'b0, rdy_last, ev_e, ed_e, edb_e, 4'd0, eo_e);
    endtask

    initial begin
        string tag;
        async_reset = 1'b1;
        serial_in   = 1'b0;
        shift_en    = 1'b0;
        flush       = 1'b0;
        data_ready  = 1'b0;
        model_reset();

        // Expected-output table, one row per clock edge.
        add_byte(8'hB2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hB2, 8'h4D, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 4'd0, 1'b0);
        add_byte(8'hB2, 1'b0, 1'b0, 8'hB2, 8'h4D, 1'b0, 1'b1, 8'hB2, 8'h4D, 1'b0);
        add_byte(8'hFF, 1'b0, 1'b1, 8'hB2, 8'h4D, 1'b0, 1'b1, 8'hB2, 8'h4D, 1'b1);
        add_row(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB2, 8'h4D, 4'd0, 1'b0);
        add_byte(8'hFF, 1'b1, 1'b1, 8'hB2, 8'h4D, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 4'd0, 1'b0);
        for (int k = 1; k <= 5; k++)
            add_row(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 4'(k), 1'b0);
        add_row(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 4'd0, 1'b0);
        add_byte(8'h3C, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h3C, 8'h3C, 1'b0);

        #1;
        check_model("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        async_reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            tag = $sformatf("row%0d", i);
            step(vecs[i].se, vecs[i].si, vecs[i].fl, vecs[i].rdy, tag);
            chk({tag, ".tv"},  32'(valid_a), 32'(vecs[i].ev));
            chk({tag, ".td"},  32'(data_a),  32'(vecs[i].ed));
            chk({tag, ".tdb"}, 32'(data_b),  32'(vecs[i].edb));
            chk({tag, ".tc"},  32'(count_a), 32'(vecs[i].ec));
            chk({tag, ".to"},  32'(ovr_a),   32'(vecs[i].eo));
        end

        // Asynchronous reset between edges while FULL with a partial word.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "pre_rst");
        chk("pre_rst.valid", 32'(valid_a), 32'd1);
        chk("pre_rst.count", 32'(count_a), 32'd4);
        #2;
        async_reset = 1'b1;
        #1;
        model_reset();
        chk("arst.data",  32'(data_a),  32'd0);
        chk("arst.valid", 32'(valid_a), 32'd0);
        chk("arst.count", 32'(count_a), 32'd0);
        check_model("arst");
        #2;
        async_reset = 1'b0;
        begin
            logic [7:0] b;
            b = 8'hA5;
            for (int i = 0; i < 8; i++) step(1'b1, b[7-i], 1'b0, 1'b0, "a5");
        end
        chk("a5.data_a", 32'(data_a), 32'hA5);
        chk("a5.data_b", 32'(data_b), 32'hA5);

        // Back-to-back stream with data_ready tied high.
        step(1'b0, 1'b0, 1'b0, 1'b1, "drain");
        hs_q.delete();
        begin
            logic [7:0] words[3];
            words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
            for (int w = 0; w < 3; w++)
                for (int i = 0; i < 8; i++)
                    step(1'b1, words[w][7-i], 1'b0, 1'b1, "stream");
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, "stream_idle");
            chk("stream.hs_count", hs_q.size(), 32'd3);
            for (int i = 0; i < 3; i++)
                chk($sformatf("stream.hs%0d", i), (i < hs_q.size()) ? hs_q[i] : 32'hDEAD, 32'(words[i]));
            chk("stream.ovr", 32'(ovr_a), 32'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom()), ($urandom_range(0, 31) == 0),
                 1'($urandom()), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
